// File: rtl/jt89_pkg.sv
// Shared encodings, widths and helpers for the JT89 register interface.
package jt89_pkg;

  localparam int unsigned TONE_W       = 10;
  localparam int unsigned VOL_W        = 4;
  localparam int unsigned CTRL_W       = 3;
  localparam int unsigned CNT_W        = 5;
  localparam int unsigned READY_CYCLES = 32;

  localparam logic        TYPE_TONE  = 1'b0;
  localparam logic        TYPE_VOL   = 1'b1;
  localparam logic [1:0]  NOISE_CH   = 2'd3;
  localparam logic [VOL_W-1:0] VOL_SILENT = 4'hF;

  typedef enum logic {RDY_IDLE, RDY_BUSY} rdy_state_e;

  // Latch bytes load the low nibble of a tone period, data bytes the upper six bits.
  function automatic logic [TONE_W-1:0] tone_next(input logic [TONE_W-1:0] cur,
                                                  input logic [5:0]        d,
                                                  input logic              is_latch);
    tone_next = is_latch ? {cur[9:4], d[3:0]} : {d[5:0], cur[3:0]};
  endfunction

endpackage

// File: rtl/jt89_reg_if_if.sv
// CPU write bus of the JT89 PSG: chip select, write strobe, data and READY.
interface jt89_reg_if_if;
  logic       cs_n;
  logic       wr_n;
  logic [7:0] din;
  logic       ready;

  modport master (output cs_n, output wr_n, output din, input ready);
  modport slave  (input cs_n, input wr_n, input din, output ready);
endinterface

// File: rtl/jt89_ready_cnt.sv
// READY wait-state emulation: holds ready low for READY_CYCLES clk_en ticks after each accepted write.
module jt89_ready_cnt
  import jt89_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic start,
  output logic ready
);

  rdy_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RDY_IDLE;
      cnt   <= '0;
      ready <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ready <= (state_n == RDY_IDLE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      RDY_IDLE: begin
        if (start) begin
          state_n = RDY_BUSY;
          cnt_n   = CNT_W'(READY_CYCLES - 1);
        end
      end
      default: begin
        // The tick that sees zero is the last of the busy window.
        if (clk_en) begin
          if (cnt == '0) state_n = RDY_IDLE;
          else           cnt_n   = cnt - CNT_W'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/jt89_reg_if.sv
// SN76489-style latch/data write decoder feeding the JT89 tone and noise generators.
// Optional READY wait-state emulation is built when JT89_READY_EN is defined.
module jt89_reg_if
  import jt89_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  jt89_reg_if_if.slave      bus,
  output logic [TONE_W-1:0] tone0,
  output logic [TONE_W-1:0] tone1,
  output logic [TONE_W-1:0] tone2,
  output logic [VOL_W-1:0]  vol0,
  output logic [VOL_W-1:0]  vol1,
  output logic [VOL_W-1:0]  vol2,
  output logic [VOL_W-1:0]  vol3,
  output logic [CTRL_W-1:0] ctrl3,
  output logic              noise_rst
);

  logic       act_q;
  logic [2:0] latch_q;
  logic       wr_act_c, wr_edge_c, accept_c, ready_c;
  logic       is_latch_c, typ_c, noise_hit_c;
  logic [1:0] ch_c;

  assign wr_act_c  = ~bus.cs_n & ~bus.wr_n;
  assign wr_edge_c = wr_act_c & ~act_q;

`ifdef JT89_READY_EN
  jt89_ready_cnt u_ready_cnt (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (accept_c),
    .ready  (ready_c)
  );
  assign accept_c = wr_edge_c & ready_c;
`else
  assign ready_c  = 1'b1;
  assign accept_c = wr_edge_c;
`endif

  assign bus.ready = ready_c;

  // Latch bytes address themselves; data bytes target the last latched register.
  assign is_latch_c  = bus.din[7];
  assign ch_c        = is_latch_c ? bus.din[6:5] : latch_q[2:1];
  assign typ_c       = is_latch_c ? bus.din[4]   : latch_q[0];
  assign noise_hit_c = accept_c & (typ_c == TYPE_TONE) & (ch_c == NOISE_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q     <= 1'b1;
      latch_q   <= '0;
      tone0     <= '0;
      tone1     <= '0;
      tone2     <= '0;
      vol0      <= VOL_SILENT;
      vol1      <= VOL_SILENT;
      vol2      <= VOL_SILENT;
      vol3      <= VOL_SILENT;
      ctrl3     <= '0;
      noise_rst <= 1'b0;
    end else begin
      act_q <= wr_act_c;
      if (accept_c) begin
        if (is_latch_c) latch_q <= bus.din[6:4];
        if (typ_c == TYPE_VOL) begin
          case (ch_c)
            2'd0:    vol0 <= bus.din[3:0];
            2'd1:    vol1 <= bus.din[3:0];
            2'd2:    vol2 <= bus.din[3:0];
            default: vol3 <= bus.din[3:0];
          endcase
        end else begin
          case (ch_c)
            2'd0:    tone0 <= tone_next(tone0, bus.din[5:0], is_latch_c);
            2'd1:    tone1 <= tone_next(tone1, bus.din[5:0], is_latch_c);
            2'd2:    tone2 <= tone_next(tone2, bus.din[5:0], is_latch_c);
            default: ctrl3 <= bus.din[2:0];
          endcase
        end
      end
      // A fresh noise write wins over the clk_en that would otherwise end the pulse.
      if (noise_hit_c)  noise_rst <= 1'b1;
      else if (clk_en)  noise_rst <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt89_reg_if.sv
// Self-checking bench for jt89_reg_if: register-level model plus directed literal checks.
module tb_jt89_reg_if;

  logic       clk, rst, clk_en;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  logic       noise_rst;

  int   checks   = 0;
  int   failures = 0;
  logic chk_en   = 1'b0;
  logic ready_low_seen = 1'b0;
  logic nr_acc;
  int   lowcnt;
  logic [1:0] ph;

  jt89_reg_if_if bus ();

  jt89_reg_if dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .bus       (bus),
    .tone0     (tone0),
    .tone1     (tone1),
    .tone2     (tone2),
    .vol0      (vol0),
    .vol1      (vol1),
    .vol2      (vol2),
    .vol3      (vol3),
    .ctrl3     (ctrl3),
    .noise_rst (noise_rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // clk_en high on every 4th rising edge; changes just after posedge.
  initial begin
    clk_en = 1'b0;
    ph     = 2'd0;
    forever begin
      @(posedge clk);
      #1;
      ph     = ph + 2'd1;
      clk_en = (ph == 2'd0);
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_prev;
  logic [1:0] m_ch;
  logic       m_typ;
  logic [9:0] m_tone [4];
  logic [3:0] m_vol  [4];
  logic [2:0] m_ctrl;
  logic       m_nr;
  int         m_busy;

  wire       w_act  = ~bus.cs_n & ~bus.wr_n;
  wire       w_take = w_act & ~m_prev & (m_busy == 0);
  wire [1:0] w_ch   = bus.din[7] ? bus.din[6:5] : m_ch;
  wire       w_typ  = bus.din[7] ? bus.din[4]   : m_typ;

  always @(posedge clk) begin
    if (rst) begin
      m_prev <= 1'b1;
      m_ch   <= 2'd0;
      m_typ  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_tone[i] <= 10'd0;
        m_vol[i]  <= 4'hF;
      end
      m_ctrl <= 3'd0;
      m_nr   <= 1'b0;
      m_busy <= 0;
    end else begin
      m_prev <= w_act;
      if (w_take) begin
        if (bus.din[7]) begin
          m_ch  <= bus.din[6:5];
          m_typ <= bus.din[4];
        end
        if (w_typ)              m_vol[w_ch]        <= bus.din[3:0];
        else if (w_ch == 2'd3)  m_ctrl             <= bus.din[2:0];
        else if (bus.din[7])    m_tone[w_ch][3:0]  <= bus.din[3:0];
        else                    m_tone[w_ch][9:4]  <= bus.din[5:0];
      end
      m_nr <= (w_take && !w_typ && w_ch == 2'd3) ? 1'b1 : (clk_en ? 1'b0 : m_nr);
`ifdef JT89_READY_EN
      if (w_take)                     m_busy <= 32;
      else if (clk_en && m_busy > 0)  m_busy <= m_busy - 1;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model",
          {13'd0, tone0, tone1, tone2, vol0, vol1, vol2, vol3, ctrl3, noise_rst, bus.ready},
          {13'd0, m_tone[0], m_tone[1], m_tone[2], m_vol[0], m_vol[1], m_vol[2], m_vol[3],
           m_ctrl, m_nr, (m_busy == 0)});
      if (!bus.ready) ready_low_seen = 1'b1;
    end
  end

  // Wait for ready (bounded), drive one byte for `hold` cycles, then one idle cycle.
  task automatic wr(input logic [7:0] d, input int hold);
    for (int t = 0; t < 300 && !bus.ready; t++) @(negedge clk);
    chk("ready_wait", {63'd0, bus.ready}, 64'd1);
    bus.din  = d;
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    @(negedge clk);
    nr_acc = noise_rst;
    for (int h = 1; h < hold; h++) @(negedge clk);
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
    bus.din  = 8'h00;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst    = 1'b0;
    @(negedge clk);
    chk("rst_tone",  {34'd0, tone0, tone1, tone2}, 64'd0);
    chk("rst_vol",   {48'd0, vol0, vol1, vol2, vol3}, 64'hFFFF);
    chk("rst_ctrl3", {61'd0, ctrl3}, 64'd0);
    chk("rst_ready", {63'd0, bus.ready}, 64'd1);
    chk("rst_nrst",  {63'd0, noise_rst}, 64'd0);

    wr(8'h8A, 3);
    wr(8'h3F, 3);
    chk("tone0_3fa", {54'd0, tone0}, 64'h3FA);

    wr(8'h9B, 3);
    wr(8'h05, 3);
    chk("vol0_5", {60'd0, vol0}, 64'd5);

    wr(8'hE6, 2);
    chk("ctrl3_6", {61'd0, ctrl3}, 64'd6);
    chk("nrst_e6", {63'd0, nr_acc}, 64'd1);
    wr(8'h03, 2);
    chk("ctrl3_3", {61'd0, ctrl3}, 64'd3);
    chk("nrst_03", {63'd0, nr_acc}, 64'd1);

    wr(8'hA1, 1);
    wr(8'h00, 1);
    chk("tone1_1", {54'd0, tone1}, 64'd1);
    wr(8'hF3, 1);
    chk("vol3_3", {60'd0, vol3}, 64'd3);

    // Write presented with reset, strobe still held after reset releases.
    bus.din  = 8'hC1;
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
    @(negedge clk);
    chk("rst_wr_tone2", {54'd0, tone2}, 64'd0);
    chk("rst_wr_vol3",  {60'd0, vol3}, 64'hF);
    wr(8'h15, 1);
    chk("latch_ch0_tone0", {54'd0, tone0}, 64'h150);
    chk("latch_ch0_tone2", {54'd0, tone2}, 64'd0);

`ifdef JT89_READY_EN
    for (int t = 0; t < 300 && !bus.ready; t++) @(negedge clk);
    while (!clk_en) @(negedge clk);
    bus.din  = 8'hDF;
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    lowcnt   = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.ready) lowcnt++;
      if (i == 1)  begin bus.cs_n = 1'b1; bus.wr_n = 1'b1; end
      if (i == 49) begin bus.din = 8'hD0; bus.cs_n = 1'b0; bus.wr_n = 1'b0; end
      if (i == 51) begin bus.cs_n = 1'b1; bus.wr_n = 1'b1; end
    end
    chk("busy_len", 64'(lowcnt), 64'd128);
    chk("vol2_drop", {60'd0, vol2}, 64'hF);
    wr(8'hD0, 2);
    chk("vol2_0", {60'd0, vol2}, 64'd0);
    // Strobe asserted while busy and held past the end of the busy window.
    bus.din  = 8'hD7;
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    repeat (160) @(negedge clk);
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
    @(negedge clk);
    chk("vol2_span", {60'd0, vol2}, 64'd0);
`else
    wr(8'h81, 1);
    wr(8'h02, 1);
    wr(8'hB4, 1);
    wr(8'hC7, 1);
    wr(8'h3F, 1);
    chk("b2b_tone0", {54'd0, tone0}, 64'h021);
    chk("b2b_vol1",  {60'd0, vol1}, 64'd4);
    chk("b2b_tone2", {54'd0, tone2}, 64'h3F7);
    chk("ready_const", {63'd0, ready_low_seen}, 64'd0);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
